// File: rtl/difftest_pkg.sv
// Shared types and decode constants for the difftest commit staging slice.
// Opcode/CSR encodings used by the skip decode, plus the event bundle.
package difftest_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_SKIP   = 7'h7b;

  localparam logic [11:0] CSR_MCYCLE = 12'hB00;

  typedef struct packed {
    logic [31:0] no;
    logic [63:0] pc;
    logic [31:0] inst;
  } evt_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  function automatic logic is_mem_op(
    input logic [6:0] op
  );
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/difftest_commit_stage_if.sv
// Writeback-to-difftest bundle: retire slots and irq in, commit
// records, trap, counters and arch event out.
interface difftest_commit_stage_if #(
  parameter int COMMIT_W = 2
);

  logic [COMMIT_W-1:0][63:0] in_pc;
  logic [COMMIT_W-1:0][31:0] in_inst;
  logic [COMMIT_W-1:0]       in_wen;
  logic [COMMIT_W-1:0][4:0]  in_wdest;
  logic [COMMIT_W-1:0][63:0] in_wdata;
  logic [COMMIT_W-1:0][63:0] in_mem_addr;
  logic [63:0]               in_a0;
  logic                      irq_take;
  logic [31:0]               irq_no;
  logic [63:0]               irq_pc;
  logic [31:0]               irq_inst;

  logic [COMMIT_W-1:0]       cmt_valid;
  logic [COMMIT_W-1:0][63:0] cmt_pc;
  logic [COMMIT_W-1:0][31:0] cmt_inst;
  logic [COMMIT_W-1:0]       cmt_skip;
  logic [COMMIT_W-1:0]       cmt_wen;
  logic [COMMIT_W-1:0][7:0]  cmt_wdest;
  logic [COMMIT_W-1:0][63:0] cmt_wdata;
  logic                      trap_valid;
  logic [7:0]                trap_code;
  logic [63:0]               trap_pc;
  logic [63:0]               cycle_cnt;
  logic [63:0]               instr_cnt;
  logic [31:0]               evt_intr_no;
  logic [63:0]               evt_pc;
  logic [31:0]               evt_inst;

  modport master (
    output in_pc, in_inst, in_wen, in_wdest, in_wdata,
    output in_mem_addr, in_a0,
    output irq_take, irq_no, irq_pc, irq_inst,
    input  cmt_valid, cmt_pc, cmt_inst, cmt_skip,
    input  cmt_wen, cmt_wdest, cmt_wdata,
    input  trap_valid, trap_code, trap_pc,
    input  cycle_cnt, instr_cnt,
    input  evt_intr_no, evt_pc, evt_inst
  );

  modport slave (
    input  in_pc, in_inst, in_wen, in_wdest, in_wdata,
    input  in_mem_addr, in_a0,
    input  irq_take, irq_no, irq_pc, irq_inst,
    output cmt_valid, cmt_pc, cmt_inst, cmt_skip,
    output cmt_wen, cmt_wdest, cmt_wdata,
    output trap_valid, trap_code, trap_pc,
    output cycle_cnt, instr_cnt,
    output evt_intr_no, evt_pc, evt_inst
  );

endinterface

// File: rtl/evt_delay_line.sv
// Enable-gated shift register with async active-low clear.
// Stage 0 takes i_d; o_q is the last stage.
module evt_delay_line #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [DEPTH-1:0][W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_q[i] <= r_q[i-1];
      end
    end
  end

  assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/difftest_commit_stage.sv
// Difftest commit staging: live/dup filtering, skip flags, trap
// detection, counters and a delayed interrupt event line.
module difftest_commit_stage
  import difftest_pkg::*;
#(
  parameter int          COMMIT_W  = 2,
  parameter int          EVT_DELAY = 3,
  parameter logic [31:0] TRAP_INST = 32'h0000006b,
  parameter logic [63:0] MMIO_BASE = 64'h80000000
) (
  input logic                    clock,
  input logic                    reset,
  difftest_commit_stage_if.slave io
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run;

  evt_t w_evt_in;
  evt_t w_evt_tap;
  logic w_evt_hot;

  logic [COMMIT_W-1:0] w_cand;
  logic [COMMIT_W-1:0] w_trap_hit;
  logic [COMMIT_W-1:0] w_skip;
  logic [COMMIT_W-1:0] w_live;
  logic                w_blk;
  logic                w_trap;
  logic [63:0]         w_trap_pc;
  logic [63:0]         w_last_nxt;
  logic [7:0]          w_pop;

  logic [COMMIT_W-1:0]       r_cmt_valid;
  logic [COMMIT_W-1:0][63:0] r_cmt_pc;
  logic [COMMIT_W-1:0][31:0] r_cmt_inst;
  logic [COMMIT_W-1:0]       r_cmt_skip;
  logic [COMMIT_W-1:0]       r_cmt_wen;
  logic [COMMIT_W-1:0][7:0]  r_cmt_wdest;
  logic [COMMIT_W-1:0][63:0] r_cmt_wdata;
  logic                      r_trap_valid;
  logic [7:0]                r_trap_code;
  logic [63:0]               r_trap_pc;
  logic [63:0]               r_cycle;
  logic [63:0]               r_instr;
  logic [63:0]               r_last_pc;

  assign w_run = (r_state == S_RUN);

  assign w_evt_in = io.irq_take
    ? '{no: io.irq_no, pc: io.irq_pc, inst: io.irq_inst}
    : '0;

  evt_delay_line #(
    .DEPTH (EVT_DELAY),
    .W     ($bits(evt_t))
  ) u_evt (
    .clk   (clock),
    .rst_n (reset),
    .i_en  (w_run),
    .i_d   (w_evt_in),
    .o_q   (w_evt_tap)
  );

  assign w_evt_hot = (w_evt_tap.no != 32'd0);

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_ch
    logic [6:0] w_op;
    logic       w_mmio;
    assign w_op   = io.in_inst[k][6:0];
    assign w_mmio = io.in_mem_addr[k] < MMIO_BASE;
    assign w_cand[k] = (io.in_inst[k] != 32'd0)
                    && (io.in_pc[k] != r_last_pc);
    assign w_trap_hit[k] = w_cand[k]
                        && (io.in_inst[k] == TRAP_INST);
    assign w_skip[k] = (w_op == OP_SKIP)
      || ((w_op == OP_SYSTEM)
          && (io.in_inst[k][31:20] == CSR_MCYCLE))
      || (is_mem_op(w_op) && w_mmio)
      || w_evt_hot;
  end

  // A trap truncates the retire group: younger slots are dropped.
  always_comb begin
    w_live     = '0;
    w_blk      = 1'b0;
    w_trap     = 1'b0;
    w_trap_pc  = '0;
    w_last_nxt = r_last_pc;
    w_pop      = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (!w_blk) begin
        w_live[k] = w_cand[k];
        if (w_trap_hit[k]) begin
          w_blk     = 1'b1;
          w_trap    = 1'b1;
          w_trap_pc = io.in_pc[k];
        end
      end
      if (w_live[k]) begin
        w_last_nxt = io.in_pc[k];
        w_pop      = w_pop + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:  if (w_trap) w_state_nxt = S_HALT;
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cmt_valid  <= '0;
      r_cmt_pc     <= '0;
      r_cmt_inst   <= '0;
      r_cmt_skip   <= '0;
      r_cmt_wen    <= '0;
      r_cmt_wdest  <= '0;
      r_cmt_wdata  <= '0;
      r_trap_valid <= 1'b0;
      r_trap_code  <= '0;
      r_trap_pc    <= '0;
      r_cycle      <= '0;
      r_instr      <= '0;
      r_last_pc    <= '0;
    end else if (w_run) begin
      r_cmt_valid <= w_evt_hot ? '0 : w_live;
      r_cmt_pc    <= io.in_pc;
      r_cmt_inst  <= io.in_inst;
      r_cmt_skip  <= w_skip;
      r_cmt_wen   <= io.in_wen;
      r_cmt_wdata <= io.in_wdata;
      for (int k = 0; k < COMMIT_W; k++) begin
        r_cmt_wdest[k] <= {3'b000, io.in_wdest[k]};
      end
      r_cycle   <= r_cycle + 64'd1;
      r_last_pc <= w_last_nxt;
      if (!w_evt_hot) begin
        r_instr <= r_instr + 64'(w_pop);
      end
      if (w_trap) begin
        r_trap_valid <= 1'b1;
        r_trap_code  <= io.in_a0[7:0];
        r_trap_pc    <= w_trap_pc;
      end
    end
  end

  assign io.cmt_valid   = r_cmt_valid;
  assign io.cmt_pc      = r_cmt_pc;
  assign io.cmt_inst    = r_cmt_inst;
  assign io.cmt_skip    = r_cmt_skip;
  assign io.cmt_wen     = r_cmt_wen;
  assign io.cmt_wdest   = r_cmt_wdest;
  assign io.cmt_wdata   = r_cmt_wdata;
  assign io.trap_valid  = r_trap_valid;
  assign io.trap_code   = r_trap_code;
  assign io.trap_pc     = r_trap_pc;
  assign io.cycle_cnt   = r_cycle;
  assign io.instr_cnt   = r_instr;
  assign io.evt_intr_no = w_evt_tap.no;
  assign io.evt_pc      = w_evt_tap.pc;
  assign io.evt_inst    = w_evt_tap.inst;

endmodule

// File: tb/tb_difftest_commit_stage.sv
// Directed bench for difftest_commit_stage (COMMIT_W=2, EVT_DELAY=3).
// Expected values are hand-computed per vector.
module tb_difftest_commit_stage;

  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] LW    = 32'h00012083;
  localparam logic [31:0] SW    = 32'h00112023;
  localparam logic [31:0] CSRMC = 32'hB00020F3;
  localparam logic [31:0] CUST  = 32'h0000007b;
  localparam logic [31:0] TRAP  = 32'h0000006b;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [63:0] exp_cyc;
  logic [63:0] exp_instr;
  bit   exp_halt;

  difftest_commit_stage_if #(.COMMIT_W(2)) dif ();

  difftest_commit_stage #(
    .COMMIT_W  (2),
    .EVT_DELAY (3),
    .TRAP_INST (32'h0000006b),
    .MMIO_BASE (64'h80000000)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .io    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (!exp_halt) exp_cyc++;
  endtask

  task automatic idle();
    dif.in_pc       = '0;
    dif.in_inst     = '0;
    dif.in_wen      = '0;
    dif.in_wdest    = '0;
    dif.in_wdata    = '0;
    dif.in_mem_addr = '0;
    dif.in_a0       = '0;
    dif.irq_take    = 1'b0;
    dif.irq_no      = '0;
    dif.irq_pc      = '0;
    dif.irq_inst    = '0;
  endtask

  task automatic slot(input int k, input logic [63:0] pc,
                      input logic [31:0] inst,
                      input logic [63:0] addr);
    dif.in_pc[k]       = pc;
    dif.in_inst[k]     = inst;
    dif.in_mem_addr[k] = addr;
  endtask

  task automatic chk_cnt(input string nm);
    n_tests++;
    if (dif.cycle_cnt !== exp_cyc) begin
      n_fail++;
      $display("FAIL %s cycle_cnt got %0d exp %0d",
               nm, dif.cycle_cnt, exp_cyc);
    end
    n_tests++;
    if (dif.instr_cnt !== exp_instr) begin
      n_fail++;
      $display("FAIL %s instr_cnt got %0d exp %0d",
               nm, dif.instr_cnt, exp_instr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (dif.cmt_valid !== 2'b00 || dif.trap_valid !== 1'b0
        || dif.cycle_cnt !== 64'd0 || dif.instr_cnt !== 64'd0
        || dif.evt_intr_no !== 32'd0) begin
      n_fail++;
      $display("FAIL reset valid=%b trap=%b cyc=%0d ins=%0d evt=%0d exp all 0",
               dif.cmt_valid, dif.trap_valid, dif.cycle_cnt,
               dif.instr_cnt, dif.evt_intr_no);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    idle();
    slot(0, 64'h80000000, ADDI, 64'h0);
    dif.in_wen[0]   = 1'b1;
    dif.in_wdest[0] = 5'd1;
    dif.in_wdata[0] = 64'd1;
    tick();
    exp_instr = 1;
    n_tests++;
    if (dif.cmt_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_valid got %b exp 01", dif.cmt_valid);
    end
    n_tests++;
    if (dif.cmt_pc[0] !== 64'h80000000 || dif.cmt_wdest[0] !== 8'h01
        || dif.cmt_skip[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_fields pc=%h wdest=%h skip=%b exp 80000000/01/0",
               dif.cmt_pc[0], dif.cmt_wdest[0], dif.cmt_skip[0]);
    end
    chk_cnt("basic");
  endtask

  task automatic test_dup();
    idle();
    slot(0, 64'h80000004, ADDI, 64'h0);
    tick();
    exp_instr = 2;
    tick();
    n_tests++;
    if (dif.cmt_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL dup_valid got %b exp 00", dif.cmt_valid);
    end
    chk_cnt("dup");
    slot(0, 64'h80000008, ADDI, 64'h0);
    slot(1, 64'h8000000c, ADDI, 64'h0);
    tick();
    exp_instr = 4;
    n_tests++;
    if (dif.cmt_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL dual_valid got %b exp 11", dif.cmt_valid);
    end
    slot(0, 64'h8000000c, ADDI, 64'h0);
    slot(1, 64'h80000010, ADDI, 64'h0);
    tick();
    exp_instr = 5;
    n_tests++;
    if (dif.cmt_valid !== 2'b10) begin
      n_fail++;
      $display("FAIL dup_ch0_valid got %b exp 10", dif.cmt_valid);
    end
    chk_cnt("dual");
  endtask

  task automatic test_skip();
    idle();
    slot(0, 64'h80000014, LW, 64'h02000000);
    tick();
    exp_instr = 6;
    n_tests++;
    if (dif.cmt_skip !== 2'b01) begin
      n_fail++;
      $display("FAIL skip_lw_low got %b exp 01", dif.cmt_skip);
    end
    slot(0, 64'h80000018, LW, 64'h80001000);
    tick();
    exp_instr = 7;
    n_tests++;
    if (dif.cmt_skip !== 2'b00) begin
      n_fail++;
      $display("FAIL skip_lw_mem got %b exp 00", dif.cmt_skip);
    end
    slot(0, 64'h8000001c, SW, 64'h10000000);
    slot(1, 64'h80000020, CSRMC, 64'h0);
    tick();
    exp_instr = 9;
    n_tests++;
    if (dif.cmt_skip !== 2'b11 || dif.cmt_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL skip_sw_csr skip=%b valid=%b exp 11/11",
               dif.cmt_skip, dif.cmt_valid);
    end
    slot(0, 64'h80000024, CUST, 64'h0);
    slot(1, 64'h80000028, ADDI, 64'h0);
    tick();
    exp_instr = 11;
    n_tests++;
    if (dif.cmt_skip !== 2'b01) begin
      n_fail++;
      $display("FAIL skip_7b got %b exp 01", dif.cmt_skip);
    end
    chk_cnt("skip");
  endtask

  task automatic test_bubbles();
    idle();
    tick();
    n_tests++;
    if (dif.cmt_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL bubble_valid got %b exp 00", dif.cmt_valid);
    end
    chk_cnt("bubble");
  endtask

  task automatic test_irq_back_to_back();
    idle();
    slot(0, 64'h80000030, ADDI, 64'h0);
    dif.irq_take = 1'b1;
    dif.irq_no   = 32'd7;
    dif.irq_pc   = 64'h80000010;
    dif.irq_inst = 32'h00000013;
    tick();
    exp_instr = 12;
    slot(0, 64'h80000034, ADDI, 64'h0);
    dif.irq_no = 32'd3;
    dif.irq_pc = 64'h80000014;
    tick();
    exp_instr = 13;
    n_tests++;
    if (dif.evt_intr_no !== 32'd0) begin
      n_fail++;
      $display("FAIL evt_early got %0d exp 0", dif.evt_intr_no);
    end
    idle();
    slot(0, 64'h80000038, ADDI, 64'h0);
    tick();
    exp_instr = 14;
    n_tests++;
    if (dif.evt_intr_no !== 32'd7 || dif.evt_pc !== 64'h80000010
        || dif.evt_inst !== 32'h00000013) begin
      n_fail++;
      $display("FAIL evt_mti no=%0d pc=%h inst=%h exp 7/80000010/13",
               dif.evt_intr_no, dif.evt_pc, dif.evt_inst);
    end
    chk_cnt("evt_arrive");
    slot(0, 64'h8000003c, ADDI, 64'h0);
    tick();
    n_tests++;
    if (dif.cmt_valid !== 2'b00 || dif.cmt_skip[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL evt_squash valid=%b skip=%b exp 00/1",
               dif.cmt_valid, dif.cmt_skip[0]);
    end
    n_tests++;
    if (dif.evt_intr_no !== 32'd3) begin
      n_fail++;
      $display("FAIL evt_second got %0d exp 3", dif.evt_intr_no);
    end
    chk_cnt("evt_squash");
    slot(0, 64'h80000040, ADDI, 64'h0);
    tick();
    n_tests++;
    if (dif.cmt_valid !== 2'b00 || dif.evt_intr_no !== 32'd0) begin
      n_fail++;
      $display("FAIL evt_squash2 valid=%b evt=%0d exp 00/0",
               dif.cmt_valid, dif.evt_intr_no);
    end
    slot(0, 64'h80000044, ADDI, 64'h0);
    tick();
    exp_instr = 15;
    n_tests++;
    if (dif.cmt_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL evt_after got %b exp 01", dif.cmt_valid);
    end
    chk_cnt("evt_after");
  endtask

  task automatic test_trap();
    idle();
    slot(0, 64'h80000048, TRAP, 64'h0);
    slot(1, 64'h8000004c, ADDI, 64'h0);
    dif.in_a0 = 64'h10005;
    tick();
    exp_instr = 16;
    exp_halt  = 1'b1;
    n_tests++;
    if (dif.trap_valid !== 1'b1 || dif.trap_code !== 8'h05
        || dif.trap_pc !== 64'h80000048) begin
      n_fail++;
      $display("FAIL trap_fields v=%b code=%h pc=%h exp 1/05/80000048",
               dif.trap_valid, dif.trap_code, dif.trap_pc);
    end
    n_tests++;
    if (dif.cmt_valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_younger valid1=%b exp 0", dif.cmt_valid[1]);
    end
    chk_cnt("trap");
    idle();
    slot(0, 64'h80000050, ADDI, 64'h0);
    dif.irq_take = 1'b1;
    dif.irq_no   = 32'd7;
    repeat (10) tick();
    chk_cnt("halt_frozen");
    n_tests++;
    if (dif.trap_valid !== 1'b1 || dif.evt_intr_no !== 32'd0
        || dif.cmt_pc[0] !== 64'h80000048) begin
      n_fail++;
      $display("FAIL halt_hold trap=%b evt=%0d pc=%h exp 1/0/80000048",
               dif.trap_valid, dif.evt_intr_no, dif.cmt_pc[0]);
    end
  endtask

  task automatic test_reset_halt();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dif.trap_valid !== 1'b0 || dif.trap_code !== 8'h00
        || dif.cycle_cnt !== 64'd0 || dif.instr_cnt !== 64'd0
        || dif.cmt_valid !== 2'b00 || dif.cmt_pc[0] !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_halt trap=%b code=%h cyc=%0d ins=%0d v=%b pc=%h exp 0",
               dif.trap_valid, dif.trap_code, dif.cycle_cnt,
               dif.instr_cnt, dif.cmt_valid, dif.cmt_pc[0]);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    exp_halt  = 1'b0;
    exp_cyc   = 0;
    exp_instr = 0;
    idle();
    slot(0, 64'h80000050, ADDI, 64'h0);
    tick();
    exp_instr = 1;
    chk_cnt("restart");
    n_tests++;
    if (dif.trap_valid !== 1'b0 || dif.cmt_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL restart trap=%b valid=%b exp 0/01",
               dif.trap_valid, dif.cmt_valid);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_cyc   = 0;
    exp_instr = 0;
    exp_halt  = 1'b0;
    test_reset();
    test_basic();
    test_dup();
    test_skip();
    test_bubbles();
    test_irq_back_to_back();
    test_trap();
    test_reset_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
